pmod_dac_writer: RTL and testbench
==================================

Name: pmod_dac_writer

Overview:
- Serial transmitter that drives an 8-bit value out to an external SPI-style DAC (AD7303-class: SYNC_n, SCLK, SDIN).
- It is the output-side counterpart of the ADC input path: game/paddle logic supplies an 8-bit value and the block shifts a 16-bit frame, a control byte followed by the data byte, onto Pmod pins.
- It sits between the game core and the top-level JPorts pin mapping.

Parameters:
- CLK_DIV, 4, sys_clk cycles per SCLK half-period; legal range is 1 or greater.
- CTRL_BYTE, 8'h00, control byte sent MSB-first ahead of the data byte.

Ports:
- sys_clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to transmit; sampled only in IDLE.
- value  input  8  data byte; latched when start is accepted.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at the end of a frame.
- dac_sync_n  output  1  frame select, active-low.
- dac_sclk  output  1  serial clock; idles high.
- dac_sdin  output  1  serial data, MSB-first.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, busy=0, done=0, dac_sync_n=1, dac_sclk=1, dac_sdin=0.
  - Shift register and divider are cleared.
  - Asserting reset mid-frame aborts the frame immediately; no done pulse is generated.
- Divider:
  - Counter runs 0..CLK_DIV-1 while busy and is held at 0 in IDLE.
  - tick = (counter==CLK_DIV-1).
  - Every state transition and SCLK toggle occurs only on a tick edge.
- IDLE:
  - On a rising edge with start=1: latch frame={CTRL_BYTE,value}, busy<=1, dac_sync_n<=0, go to SETUP.
- SETUP:
  - Lasts one half-period (CLK_DIV cycles), with dac_sclk=1 and dac_sdin=frame[15].
  - On tick: dac_sclk<=0, go to SHIFT with bit index 15.
- SHIFT, per bit:
  - Low half: dac_sclk=0, dac_sdin=current bit.
  - On tick: dac_sclk<=1 (the DAC samples on this rising edge).
  - High half: on tick, if bit index>0, then dac_sclk<=0, dac_sdin<=next bit, index decrements; otherwise go to HOLD.
  - dac_sdin changes only on SCLK falling transitions.
  - 16 bits take 32 half-periods.
- HOLD:
  - Lasts one half-period with dac_sclk=1 and dac_sync_n=0.
  - On tick: dac_sync_n<=1, busy<=0, done<=1 for one cycle, dac_sdin<=0, go to IDLE.
- Timing:
  - busy is high for exactly 34*CLK_DIV cycles.
  - done is asserted in the first cycle with busy=0.
  - start may be accepted in the cycle after done, which allows back-to-back frames separated by one IDLE cycle.
- start and value:
  - start while busy is ignored (not queued).
  - Changes to value while busy have no effect on the frame in flight.
- Widths:
  - Divider width is $clog2(CLK_DIV) bits, minimum 1.
  - Bit index is 4 bits.
- With CLK_DIV=1, each half-period is one sys_clk cycle; all rules above still hold.

Optional Feature:
- Macro DAC_AUTO_UPDATE_EN.
- Defined:
  - The start port is ignored.
  - The block holds an 8-bit last_sent register, reset to 8'h00.
  - An internal request is raised in IDLE when value!=last_sent, and also once on the first IDLE cycle after reset (forced initial write).
  - last_sent is loaded on frame acceptance.
  - value is therefore transmitted automatically whenever it changes, with at most one frame in flight; the most recent value is sent after the current frame completes.
- Undefined:
  - No last_sent register; frames are sent only on start.

Test Plan:
- CLK_DIV=4, CTRL_BYTE=8'h00, pulse start with value=8'hA5:
  - busy is high for 136 cycles.
  - 16 SCLK rising edges occur while dac_sync_n=0.
  - Bits captured on the rising edges = 16'h00A5.
  - done pulses once, and dac_sync_n returns high.
- CLK_DIV=1, CTRL_BYTE=8'h3C, value=8'hFF:
  - busy lasts 34 cycles.
  - Captured frame = 16'h3CFF.
  - SCLK half-periods are each 1 cycle.
- Mid-frame start and value change:
  - Start with value=8'h12; at cycle 20 pulse start with value=8'h34.
  - Only 16'h0012 is sent; exactly one done pulse.
- Back-to-back:
  - Hold start=1 continuously with value=8'h01, then 8'h02.
  - Two frames are sent, separated by exactly one IDLE cycle with dac_sync_n=1.
- Async reset mid-frame:
  - Assert reset at bit 7 between clock edges.
  - Outputs go immediately to sync_n=1, sclk=1, sdin=0, busy=0, with no done pulse.
  - A following start sends a full correct frame.
- DAC_AUTO_UPDATE_EN defined:
  - After reset, one frame 16'h0000 is sent.
  - Set value=8'h80: one frame 16'h0080 follows.
  - Holding value constant produces no further frames.
  - Changing value twice during a frame yields only the final value as the next frame.

Source files
------------

// File: rtl/pmod_dac_writer.sv
// Shifts {CTRL_BYTE, value} MSB-first to an AD7303-class DAC; a frame keeps busy high for 34*CLK_DIV cycles.
// start is ignored while busy. Optional DAC_AUTO_UPDATE_EN sends value automatically whenever it changes.
module pmod_dac_writer #(
  parameter int          CLK_DIV   = 4,
  parameter logic [7:0]  CTRL_BYTE = 8'h00
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic       dac_sync_n,
  output logic       dac_sclk,
  output logic       dac_sdin
);

  localparam int               DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [15:0]      frame, frame_nxt;
  logic [3:0]       bit_idx, bit_idx_nxt;
  logic             busy_nxt, done_nxt, sync_n_nxt, sclk_nxt, sdin_nxt;
  logic             tick;
  logic             req;

`ifdef DAC_AUTO_UPDATE_EN
  logic [7:0] last_sent;
  logic       first_pend;
  logic       unused_start;

  assign unused_start = start;
  // first_pend forces one write after reset even if value matches last_sent
  assign req = first_pend || (value != last_sent);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      last_sent  <= 8'h00;
      first_pend <= 1'b1;
    end else if (state == IDLE && req) begin
      last_sent  <= value;
      first_pend <= 1'b0;
    end
  end
`else
  assign req = start;
`endif

  assign tick = (div_cnt == DIV_MAX);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div_cnt    <= '0;
      frame      <= '0;
      bit_idx    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dac_sync_n <= 1'b1;
      dac_sclk   <= 1'b1;
      dac_sdin   <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      frame      <= frame_nxt;
      bit_idx    <= bit_idx_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      dac_sync_n <= sync_n_nxt;
      dac_sclk   <= sclk_nxt;
      dac_sdin   <= sdin_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    frame_nxt   = frame;
    bit_idx_nxt = bit_idx;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    sync_n_nxt  = dac_sync_n;
    sclk_nxt    = dac_sclk;
    sdin_nxt    = dac_sdin;

    if (state == IDLE || tick) div_cnt_nxt = '0;
    else                       div_cnt_nxt = div_cnt + DIV_W'(1);

    case (state)
      IDLE: begin
        if (req) begin
          frame_nxt  = {CTRL_BYTE, value};
          busy_nxt   = 1'b1;
          sync_n_nxt = 1'b0;
          sdin_nxt   = CTRL_BYTE[7];
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_nxt    = 1'b0;
          bit_idx_nxt = 4'd15;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        // data only moves on the falling SCLK transition so it is stable at the DAC's rising-edge sample
        if (tick) begin
          if (!dac_sclk) begin
            sclk_nxt = 1'b1;
          end else if (bit_idx != 4'd0) begin
            sclk_nxt    = 1'b0;
            sdin_nxt    = frame[bit_idx - 4'd1];
            bit_idx_nxt = bit_idx - 4'd1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          sync_n_nxt = 1'b1;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          sdin_nxt   = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmod_dac_writer.sv
// Bench for pmod_dac_writer: two instances (CLK_DIV=4/CTRL 00, CLK_DIV=1/CTRL 3C) checked cycle by cycle
// against a frame-timeline model, plus literal checks of captured frames and timing.
module tb_pmod_dac_writer;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [1:0] start_v = 2'b00;
  logic [7:0] value_v [2];
  logic [1:0] busy_w, done_w, sync_w, sclk_w, sdin_w;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  pmod_dac_writer #(.CLK_DIV(4), .CTRL_BYTE(8'h00)) dut_a (
    .sys_clk(sys_clk), .reset(reset), .start(start_v[0]), .value(value_v[0]),
    .busy(busy_w[0]), .done(done_w[0]), .dac_sync_n(sync_w[0]), .dac_sclk(sclk_w[0]), .dac_sdin(sdin_w[0]));

  pmod_dac_writer #(.CLK_DIV(1), .CTRL_BYTE(8'h3C)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .start(start_v[1]), .value(value_v[1]),
    .busy(busy_w[1]), .done(done_w[1]), .dac_sync_n(sync_w[1]), .dac_sclk(sclk_w[1]), .dac_sdin(sdin_w[1]));

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [7:0] ctrl_of(input int i);
    return (i == 0) ? 8'h00 : 8'h3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a frame is a timeline of 34 half-periods ----------------
  bit          m_busy [2];
  bit          m_done [2];
  int          m_t    [2];
  logic [15:0] m_frame[2];
  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
`ifdef DAC_AUTO_UPDATE_EN
  bit          m_first[2];
  logic [7:0]  m_last [2];
`endif

  function automatic bit wants(input int i);
`ifdef DAC_AUTO_UPDATE_EN
    return m_first[i] || (value_v[i] != m_last[i]);
`else
    return start_v[i];
`endif
  endfunction

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 0; m_done[i] = 0; m_t[i] = 0; m_frame[i] = 16'h0;
`ifdef DAC_AUTO_UPDATE_EN
        m_first[i] = 1; m_last[i] = 8'h00;
`endif
      end
      exp_a.delete();
      exp_b.delete();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 0;
        if (m_busy[i]) begin
          m_t[i]++;
          if (m_t[i] == 34 * div_of(i)) begin
            m_busy[i] = 0;
            m_done[i] = 1;
          end
        end else if (wants(i)) begin
          m_busy[i]  = 1;
          m_t[i]     = 0;
          m_frame[i] = {ctrl_of(i), value_v[i]};
`ifdef DAC_AUTO_UPDATE_EN
          m_first[i] = 0;
          m_last[i]  = value_v[i];
`endif
          if (i == 0) exp_a.push_back(m_frame[i]);
          else        exp_b.push_back(m_frame[i]);
        end
      end
    end
  end

  // {sync_n, sclk, sdin}: half 0 = setup, halves 1..32 = low/high per bit, half 33 = hold
  function automatic logic [2:0] exp_pins(input int i);
    int h, k;
    if (!m_busy[i]) return 3'b110;
    h = m_t[i] / div_of(i);
    if (h == 0) return {1'b0, 1'b1, m_frame[i][15]};
    if (h <= 32) begin
      k = (h - 1) / 2;
      return {1'b0, ((h - 1) % 2) == 1, m_frame[i][15 - k]};
    end
    return {1'b0, 1'b1, m_frame[i][0]};
  endfunction

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d busy", i), 32'(busy_w[i]), 32'(m_busy[i]));
      check($sformatf("dut%0d done", i), 32'(done_w[i]), 32'(m_done[i]));
      check($sformatf("dut%0d pins{sync_n,sclk,sdin}", i), 32'({sync_w[i], sclk_w[i], sdin_w[i]}), 32'(exp_pins(i)));
    end
  end

  // ---------------- pin monitor: captures bits on SCLK rising edges ----------------
  logic [1:0]  p_sclk = 2'b11;
  logic [1:0]  p_sync = 2'b11;
  logic [15:0] sh[2];
  logic [15:0] last_cap[2];
  int edges[2], brun[2], idle_run[2];
  int frames[2], dones[2], last_busy[2], last_edges[2], last_gap[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      sh[i] = 0; last_cap[i] = 0; edges[i] = 0; brun[i] = 0; idle_run[i] = 0;
      frames[i] = 0; dones[i] = 0; last_busy[i] = 0; last_edges[i] = 0; last_gap[i] = 0;
    end
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        sh[i] = 0; edges[i] = 0; brun[i] = 0; idle_run[i] = 0;
      end else begin
        if (done_w[i]) dones[i]++;
        if (busy_w[i]) brun[i]++;
        else if (brun[i] != 0) begin last_busy[i] = brun[i]; brun[i] = 0; end
        if (!sync_w[i] && sclk_w[i] && !p_sclk[i]) begin
          sh[i] = {sh[i][14:0], sdin_w[i]};
          edges[i]++;
        end
        if (sync_w[i] && !p_sync[i]) begin
          logic [15:0] e;
          bit have;
          have = (i == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
          last_cap[i]   = sh[i];
          last_edges[i] = edges[i];
          frames[i]++;
          if (!have) begin
            checks++; errors++;
            $display("FAIL dut%0d unexpected frame: got %04h, expected none", i, sh[i]);
          end else begin
            e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
            check($sformatf("dut%0d frame vs model", i), 32'(sh[i]), 32'(e));
          end
          sh[i] = 0; edges[i] = 0;
        end
        if (sync_w[i]) idle_run[i]++;
        else if (p_sync[i]) begin last_gap[i] = idle_run[i]; idle_run[i] = 0; end
      end
      p_sclk[i] = sclk_w[i];
      p_sync[i] = sync_w[i];
    end
  end

  task automatic wait_frames(input int i, input int target, input int budget);
    int n = 0;
    while (frames[i] < target && n < budget) begin
      @(posedge sys_clk);
      n++;
    end
    check($sformatf("dut%0d frame count", i), 32'(frames[i]), 32'(target));
  endtask

  task automatic pulse_start(input int i, input logic [7:0] v);
    @(negedge sys_clk);
    value_v[i] = v;
    start_v[i] = 1'b1;
    @(negedge sys_clk);
    start_v[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f, d, i, n;
    value_v[0] = 8'h00;
    value_v[1] = 8'h00;
    repeat (3) @(negedge sys_clk);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("dut%0d reset busy", j), 32'(busy_w[j]), 0);
      check($sformatf("dut%0d reset done", j), 32'(done_w[j]), 0);
      check($sformatf("dut%0d reset pins", j), 32'({sync_w[j], sclk_w[j], sdin_w[j]}), 32'(3'b110));
    end
    reset = 1'b0;

`ifndef DAC_AUTO_UPDATE_EN
    // single frame, CLK_DIV=4
    d = dones[0]; f = frames[0];
    pulse_start(0, 8'hA5);
    wait_frames(0, f + 1, 400);
    repeat (3) @(negedge sys_clk);
    check("A5 frame", 32'(last_cap[0]), 32'h00A5);
    check("A5 busy cycles", 32'(last_busy[0]), 136);
    check("A5 sclk edges", 32'(last_edges[0]), 16);
    check("A5 done pulses", 32'(dones[0] - d), 1);
    check("A5 sync_n idle", 32'(sync_w[0]), 1);

    // single frame, CLK_DIV=1
    f = frames[1];
    pulse_start(1, 8'hFF);
    wait_frames(1, f + 1, 100);
    repeat (2) @(negedge sys_clk);
    check("FF frame", 32'(last_cap[1]), 32'h3CFF);
    check("FF busy cycles", 32'(last_busy[1]), 34);
    check("FF sclk edges", 32'(last_edges[1]), 16);

    // start and value change mid-frame are ignored
    d = dones[0]; f = frames[0];
    pulse_start(0, 8'h12);
    repeat (18) @(negedge sys_clk);
    value_v[0] = 8'h34; start_v[0] = 1'b1;
    @(negedge sys_clk);
    start_v[0] = 1'b0;
    wait_frames(0, f + 1, 400);
    repeat (200) @(negedge sys_clk);
    check("mid-frame frame", 32'(last_cap[0]), 32'h0012);
    check("mid-frame frame count", 32'(frames[0]), 32'(f + 1));
    check("mid-frame done pulses", 32'(dones[0] - d), 1);

    // back-to-back with start held
    f = frames[1];
    @(negedge sys_clk);
    value_v[1] = 8'h01; start_v[1] = 1'b1;
    @(negedge sys_clk);
    value_v[1] = 8'h02;
    wait_frames(1, f + 1, 100);
    check("b2b first frame", 32'(last_cap[1]), 32'h3C01);
    @(negedge sys_clk);
    start_v[1] = 1'b0;
    wait_frames(1, f + 2, 100);
    check("b2b second frame", 32'(last_cap[1]), 32'h3C02);
    check("b2b idle gap", 32'(last_gap[1]), 1);

    // async reset in the middle of bit 7
    d = dones[0]; f = frames[0];
    pulse_start(0, 8'h5A);
    repeat (70) @(posedge sys_clk);
    #2 reset = 1'b1;
    #1;
    check("async reset busy", 32'(busy_w[0]), 0);
    check("async reset pins", 32'({sync_w[0], sclk_w[0], sdin_w[0]}), 32'(3'b110));
    repeat (2) @(negedge sys_clk);
    reset = 1'b0;
    repeat (5) @(negedge sys_clk);
    check("async reset no done", 32'(dones[0]), 32'(d));
    check("async reset no frame", 32'(frames[0]), 32'(f));
    pulse_start(0, 8'hC3);
    wait_frames(0, f + 1, 400);
    repeat (2) @(negedge sys_clk);
    check("post-reset frame", 32'(last_cap[0]), 32'h00C3);
    check("post-reset busy cycles", 32'(last_busy[0]), 136);

    // randomized start pulses, holds and value churn
    for (int it = 0; it < 40; it++) begin
      i = $urandom_range(0, 1);
      @(negedge sys_clk);
      value_v[i] = 8'($urandom);
      start_v[i] = 1'b1;
      n = $urandom_range(1, 3);
      repeat (n) @(negedge sys_clk);
      start_v[i] = 1'b0;
      n = (i == 0) ? $urandom_range(0, 160) : $urandom_range(0, 45);
      repeat (n) begin
        @(negedge sys_clk);
        if ($urandom_range(0, 7) == 0) value_v[i] = 8'($urandom);
      end
    end
`else
    // forced initial write, then change-driven writes
    wait_frames(0, 1, 400);
    check("auto initial frame", 32'(last_cap[0]), 32'h0000);
    wait_frames(1, 1, 100);
    check("auto initial frame B", 32'(last_cap[1]), 32'h3C00);
    @(negedge sys_clk);
    value_v[0] = 8'h80;
    wait_frames(0, 2, 400);
    check("auto 80 frame", 32'(last_cap[0]), 32'h0080);
    check("auto 80 busy cycles", 32'(last_busy[0]), 136);
    repeat (400) @(negedge sys_clk);
    check("auto constant value no frames", 32'(frames[0]), 2);

    f = frames[0];
    value_v[0] = 8'h44;
    repeat (10) @(negedge sys_clk);
    value_v[0] = 8'h11;
    repeat (10) @(negedge sys_clk);
    value_v[0] = 8'h22;
    wait_frames(0, f + 2, 800);
    check("auto latest value frame", 32'(last_cap[0]), 32'h0022);
    repeat (400) @(negedge sys_clk);
    check("auto no extra frames", 32'(frames[0]), 32'(f + 2));

    for (int it = 0; it < 30; it++) begin
      i = $urandom_range(0, 1);
      @(negedge sys_clk);
      value_v[i] = 8'($urandom);
      n = $urandom_range(1, 200);
      repeat (n) @(negedge sys_clk);
    end
`endif

    // drain outstanding frames
    n = 0;
    while ((m_busy[0] || m_busy[1] || busy_w != 2'b00 || exp_a.size() != 0 || exp_b.size() != 0) && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    repeat (3) @(negedge sys_clk);
    check("pending expected frames", 32'(exp_a.size() + exp_b.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
